bp_burst_stream_arbiter: RTL and testbench
==========================================

# bp_burst_stream_arbiter

Round-robin arbiter sharing one BedRock Burst output stream among `num_req_p` Burst sources, typically several wormhole-to-Burst converters feeding a single memory-side consumer. Arbitration happens on header beats; once a header with data is granted, the grant is locked until that message's last data beat is accepted. Both header and data paths are zero-latency passthroughs with no data buffering; the only state is the grant, the arbitration pointer and the FSM.

## Interface
- `num_req_p`, 2: number of Burst sources; must be ≥2.
- `hdr_width_p`, "inv": Burst header width.
- `data_width_p`, "inv": Burst data beat width.
- `lg_num_req_lp`, derived `BSG_SAFE_CLOG2(num_req_p)`: grant index width.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `hdr_i` in `num_req_p*hdr_width_p`: per-source header, source k at bits `[k*hdr_width_p +: hdr_width_p]`.
- `hdr_v_i` in `num_req_p`: per-source header valid.
- `hdr_ready_and_o` out `num_req_p`: per-source header ready.
- `has_data_i` in `num_req_p`: per-source flag, qualified by `hdr_v_i`; header is followed by data beats.
- `data_i` in `num_req_p*data_width_p`: per-source data beats, packed as `hdr_i`.
- `data_v_i` in `num_req_p`: per-source data valid.
- `data_ready_and_o` out `num_req_p`: per-source data ready.
- `last_data_i` in `num_req_p`: per-source last-beat flag, qualified by `data_v_i`.
- `hdr_o` out `hdr_width_p`, `hdr_v_o` out 1, `hdr_ready_and_i` in 1, `has_data_o` out 1: arbitrated header stream.
- `data_o` out `data_width_p`, `data_v_o` out 1, `data_ready_and_i` in 1, `last_data_o` out 1: arbitrated data stream.
- `grant_id_o` out `lg_num_req_lp`: index of the source currently owning the output; valid when `hdr_v_o | data_v_o`.

## Operation
- FSM states:
  - `e_idle`: no grant held.
  - `e_hdr`: header presented but not yet accepted; grant frozen.
  - `e_data`: data phase; grant locked.
- Round-robin pointer `rr_r`:
  - Search order is `rr_r, rr_r+1, …` mod `num_req_p`.
  - After any completed message from source g, `rr_r <= g+1` mod `num_req_p`. This includes a header-only message.
- `e_idle`:
  - Select the first valid source from `rr_r` combinationally.
  - Drive its header to the output; `hdr_v_o = |hdr_v_i`.
  - On accept (`hdr_v_o & hdr_ready_and_i`): if `has_data` is set, latch grant and go to `e_data`; otherwise advance `rr_r` and stay in `e_idle`.
  - If `hdr_v_o & ~hdr_ready_and_i`: latch grant and go to `e_hdr`.
- `e_hdr`:
  - Output the latched source's header only.
  - The selection never changes even if a higher-priority source raises valid.
  - On accept, transition exactly as in `e_idle`.
- `e_data`:
  - `data_o`, `data_v_o` and `last_data_o` come from the granted source.
  - `data_ready_and_o[g] = data_ready_and_i`; all other data readies are 0.
  - All `hdr_ready_and_o` are 0 and `hdr_v_o` = 0.
  - On accept with `last_data_i[g]`: advance `rr_r` and go to `e_idle`.
- Readies outside the granted header path are always 0.
- `data_v_o` is 0 outside `e_data`, and data from ungranted sources is ignored.
- Sources must obey valid-then-ready: valid and payload are held until accepted.

## Timing
- Header: combinational path `hdr_v_i`/`hdr_i` → `hdr_o` with zero latency; `hdr_ready_and_i` → `hdr_ready_and_o[g]` is combinational.
- Data: same zero-latency passthrough.
- First data beat may be accepted the cycle after header accept; back-to-back beats every cycle.
- Next message's header may be accepted the cycle after the previous message's last-beat accept. That gives peak throughput of one header-only message per cycle, rotating among sources.
- Reset (`reset_n_i`=0 at a clock edge):
  - state <= `e_idle`, `rr_r` <= 0.
  - While reset is asserted, all `*_v_o` and `*_ready_and_o` are 0 and `grant_id_o` is 0.
  - Reset mid-message abandons the grant; no beats are emitted after it.
- Simultaneous requests: the lowest index at or after `rr_r` wins.
- Wrap-around: with `rr_r` = `num_req_p-1`, a request from `num_req_p-1` beats source 0.

## Test plan
- **Reset:** hold `reset_n_i`=0 with all valids high → all output valids and readies 0. Release → source 0 is granted first.
- **Fairness:** 3 sources, each sending continuous header-only messages with `hdr_ready_and_i`=1 → grant sequence 0,1,2,0,1,2.
- **Lock:**
  - Source 1 sends a header with `has_data`=1 and 4 beats, with source 0 valid throughout → all 4 beats come from source 1 and `last_data_o` is set on beat 4 only.
  - Source 0's header is accepted the cycle after.
- **Backpressure freeze:**
  - `rr_r`=2, source 2 header valid, `hdr_ready_and_i`=0 for 3 cycles, source 0 raises valid in cycle 2 → `hdr_o` and `grant_id_o`=2 stay stable until accept.
- **Data stall:** toggle `data_ready_and_i` 1,0,1,0 during a 2-beat message → exactly 2 beats transferred; `rr_r` advances only on the last-beat accept.
- **Mid-message reset:** assert reset after beat 1 of 3 → state returns to `e_idle`, no further `data_v_o`, and `rr_r`=0.

Source files
------------

// File: rtl/bp_burst_stream_arbiter.sv
// Round-robin arbiter merging several BedRock Burst sources onto one Burst stream.
// Grants are decided on header beats and stay locked through the message's data beats.
module bp_burst_stream_arbiter #(
  parameter int num_req_p     = 2,
  parameter int hdr_width_p   = 64,
  parameter int data_width_p  = 64,
  localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,

  input  logic [num_req_p*hdr_width_p-1:0]  hdr_i,
  input  logic [num_req_p-1:0]              hdr_v_i,
  output logic [num_req_p-1:0]              hdr_ready_and_o,
  input  logic [num_req_p-1:0]              has_data_i,

  input  logic [num_req_p*data_width_p-1:0] data_i,
  input  logic [num_req_p-1:0]              data_v_i,
  output logic [num_req_p-1:0]              data_ready_and_o,
  input  logic [num_req_p-1:0]              last_data_i,

  output logic [hdr_width_p-1:0]            hdr_o,
  output logic                              hdr_v_o,
  input  logic                              hdr_ready_and_i,
  output logic                              has_data_o,

  output logic [data_width_p-1:0]           data_o,
  output logic                              data_v_o,
  input  logic                              data_ready_and_i,
  output logic                              last_data_o,

  output logic [lg_num_req_lp-1:0]          grant_id_o
);

  typedef enum logic [1:0] {e_idle, e_hdr, e_data} state_e;

  state_e                   state_q, state_d;
  logic [lg_num_req_lp-1:0] grant_q, grant_d;
  logic [lg_num_req_lp-1:0] rr_q, rr_d;
  logic [lg_num_req_lp-1:0] rr_sel;
  logic [lg_num_req_lp-1:0] sel;

  logic [hdr_width_p-1:0]  hdr_arr  [num_req_p];
  logic [data_width_p-1:0] data_arr [num_req_p];

  function automatic logic [lg_num_req_lp-1:0] rr_next(input logic [lg_num_req_lp-1:0] g);
    return (g == lg_num_req_lp'(num_req_p - 1)) ? '0 : g + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_src
      assign hdr_arr[gi]  = hdr_i[gi*hdr_width_p +: hdr_width_p];
      assign data_arr[gi] = data_i[gi*data_width_p +: data_width_p];
      assign hdr_ready_and_o[gi]  = hdr_v_o & hdr_ready_and_i & (sel == lg_num_req_lp'(gi));
      assign data_ready_and_o[gi] = reset_n_i & (state_q == e_data) & data_ready_and_i
                                    & (grant_q == lg_num_req_lp'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    int idx;
    rr_sel = rr_q;
    idx    = 0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (hdr_v_i[lg_num_req_lp'(idx)]) rr_sel = lg_num_req_lp'(idx);
    end
  end

  // Once a header has been shown it is frozen on grant_q until accepted.
  assign sel = (state_q == e_idle) ? rr_sel : grant_q;

  assign hdr_v_o     = reset_n_i & ((state_q == e_idle) ? (|hdr_v_i)
                                   : ((state_q == e_hdr) & hdr_v_i[grant_q]));
  assign hdr_o       = hdr_arr[sel];
  assign has_data_o  = hdr_v_o & has_data_i[sel];
  assign data_v_o    = reset_n_i & (state_q == e_data) & data_v_i[grant_q];
  assign data_o      = data_arr[grant_q];
  assign last_data_o = data_v_o & last_data_i[grant_q];
  assign grant_id_o  = reset_n_i ? sel : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      e_idle, e_hdr: begin
        if (hdr_v_o) begin
          grant_d = sel;
          if (!hdr_ready_and_i) begin
            state_d = e_hdr;
          end else if (has_data_i[sel]) begin
            state_d = e_data;
          end else begin
            state_d = e_idle;
            rr_d    = rr_next(sel);
          end
        end
      end
      e_data: begin
        if (data_v_o & data_ready_and_i & last_data_i[grant_q]) begin
          state_d = e_idle;
          rr_d    = rr_next(grant_q);
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_bp_burst_stream_arbiter.sv
// Randomized bench for bp_burst_stream_arbiter: sources generate whole Burst messages and a
// message-ownership model predicts every output each cycle.
module tb_bp_burst_stream_arbiter;
  localparam int N  = 3;
  localparam int HW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*HW-1:0] hdr_i;
  logic [N-1:0]    hdr_v_i, hdr_ready_and_o, has_data_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    data_v_i, data_ready_and_o, last_data_i;
  logic [HW-1:0]   hdr_o;
  logic            hdr_v_o, hdr_ready_and_i, has_data_o;
  logic [DW-1:0]   data_o;
  logic            data_v_o, data_ready_and_i, last_data_o;
  logic [1:0]      grant_id_o;

  always #5 clk = ~clk;

  bp_burst_stream_arbiter #(.num_req_p(N), .hdr_width_p(HW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .hdr_i(hdr_i), .hdr_v_i(hdr_v_i), .hdr_ready_and_o(hdr_ready_and_o), .has_data_i(has_data_i),
    .data_i(data_i), .data_v_i(data_v_i), .data_ready_and_o(data_ready_and_o),
    .last_data_i(last_data_i),
    .hdr_o(hdr_o), .hdr_v_o(hdr_v_o), .hdr_ready_and_i(hdr_ready_and_i), .has_data_o(has_data_o),
    .data_o(data_o), .data_v_o(data_v_o), .data_ready_and_i(data_ready_and_i),
    .last_data_o(last_data_o), .grant_id_o(grant_id_o)
  );

  int checks   = 0;
  int failures = 0;

  // Source-side message state: phase 0 = idle, 1 = header pending, 2 = sending data.
  logic [HW-1:0] s_hdr [N];
  logic [DW-1:0] s_dat [N];
  logic          s_hv [N], s_hd [N], s_dv [N], s_last [N];
  int            phase [N], beats [N];

  // Reference: which source owns the output, whether its header is done, and the rotation start.
  int owner;
  bit in_data;
  int rr;
  int grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_val, input int mode, input bit keep_src);
    int            g;
    bit            found;
    logic          exp_hv, exp_dv;
    logic [N-1:0]  exp_hr, exp_dr;
    @(negedge clk);
    reset_n = rst_val;
    for (int k = 0; k < N; k++) begin
      hdr_i[k*HW +: HW] = s_hdr[k];
      hdr_v_i[k]        = s_hv[k];
      has_data_i[k]     = s_hd[k];
      data_i[k*DW +: DW] = s_dat[k];
      data_v_i[k]       = s_dv[k];
      last_data_i[k]    = s_last[k];
    end
    hdr_ready_and_i  = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    data_ready_and_i = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;

    g = 0; found = 0; exp_hv = 0; exp_dv = 0; exp_hr = '0; exp_dr = '0;
    if (rst_val) begin
      if (in_data) begin
        g = owner;
        exp_dv = s_dv[g];
        exp_dr[g] = data_ready_and_i;
      end else if (owner >= 0) begin
        g = owner;
        exp_hv = s_hv[g];
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (rr + i) % N;
          if (!found && s_hv[k]) begin g = k; found = 1; end
        end
        exp_hv = found;
      end
      if (exp_hv) exp_hr[g] = hdr_ready_and_i;
    end

    chk("hdr_v", hdr_v_o, exp_hv);
    chk("data_v", data_v_o, exp_dv);
    chk("hdr_ready", hdr_ready_and_o, exp_hr);
    chk("data_ready", data_ready_and_o, exp_dr);
    if (!rst_val) chk("grant_in_reset", grant_id_o, 0);
    if (exp_hv) begin
      chk("hdr_grant", grant_id_o, g);
      chk("hdr_payload", hdr_o, s_hdr[g]);
      chk("has_data", has_data_o, s_hd[g]);
    end
    if (exp_dv) begin
      chk("data_grant", grant_id_o, g);
      chk("data_payload", data_o, s_dat[g]);
      chk("last_data", last_data_o, (beats[g] == 1));
    end

    if (!rst_val) begin
      owner = -1; in_data = 0; rr = 0;
      if (!keep_src) begin
        for (int k = 0; k < N; k++) begin
          phase[k] = 0; s_hv[k] = 0; s_dv[k] = 0;
        end
      end
    end else begin
      if (exp_hv && hdr_ready_and_i) begin
        if (mode == 1) grant_log.push_back(int'(grant_id_o));
        s_hv[g] = 0;
        if (s_hd[g]) begin
          owner = g; in_data = 1; phase[g] = 2; beats[g] = $urandom_range(1, 4);
        end else begin
          owner = -1; rr = (g + 1) % N; phase[g] = 0;
        end
      end else if (exp_hv) begin
        owner = g;
      end
      if (exp_dv && data_ready_and_i) begin
        s_dv[g] = 0;
        beats[g]--;
        if (beats[g] == 0) begin
          owner = -1; in_data = 0; rr = (g + 1) % N; phase[g] = 0;
        end
      end
    end

    for (int k = 0; k < N; k++) begin
      if (phase[k] == 0 && (mode == 1 || $urandom_range(0, 3) == 0)) begin
        phase[k] = 1;
        s_hv[k]  = 1;
        s_hdr[k] = HW'($urandom);
        s_hd[k]  = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end else if (phase[k] == 2 && !s_dv[k] && $urandom_range(0, 2) != 0) begin
        s_dv[k]   = 1;
        s_dat[k]  = DW'($urandom);
        s_last[k] = (beats[k] == 1);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    hdr_i = '0; hdr_v_i = '0; has_data_i = '0;
    data_i = '0; data_v_i = '0; last_data_i = '0;
    hdr_ready_and_i = 1'b0; data_ready_and_i = 1'b0;
    owner = -1; in_data = 0; rr = 0;
    for (int k = 0; k < N; k++) begin
      phase[k] = 1; beats[k] = 0;
      s_hv[k] = 1; s_hd[k] = 0; s_hdr[k] = HW'($urandom);
      s_dv[k] = 1; s_dat[k] = DW'($urandom); s_last[k] = 1;
    end

    // Reset with every valid high, then continuous header-only traffic.
    repeat (3) step(1'b0, 1, 1'b1);
    for (int k = 0; k < N; k++) s_dv[k] = 0;
    repeat (12) step(1'b1, 1, 1'b0);
    chk("fair_count", (grant_log.size() >= 6), 1);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk("fair_seq", grant_log[i], i % N);
    end

    // Randomized mixed traffic with occasional mid-message resets.
    repeat (4000) step(($urandom_range(0, 299) != 0), 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
